alarm_clk_ram_arbiter: RTL and testbench
========================================

Name: alarm_clk_ram_arbiter

Overview:
Two-requester arbiter that shares the single-port on-chip RAM (2048 x 32, byte-enabled, 1-cycle read latency) between the Nios data master (port m0) and the alarm/time-keeping engine (port m1). It presents an Avalon-MM pipelined slave per requester and drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs. Round-robin grant, one transaction per clock, with read-data return tagged to the issuing requester.

Parameters:
ADDR_W, 11, RAM word-address width.
DATA_W, 32, data width; byteenable width is DATA_W/8.
LOCK_MAX, 64, maximum idle cycles a lock owner may hold the RAM (ARB_LOCK_EN only).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
freeze  in  1  stall request from the debug core; blocks all new grants
mX_address  in  ADDR_W  word address, X = 0 or 1
mX_byteenable  in  DATA_W/8  byte lanes
mX_read  in  1  read request
mX_write  in  1  write request
mX_writedata  in  DATA_W  write data
mX_lock  in  1  hold grant across transactions (ARB_LOCK_EN only; otherwise ignored)
mX_waitrequest  out  1  request not accepted this cycle
mX_readdata  out  DATA_W  read data
mX_readdatavalid  out  1  mX_readdata valid this cycle
ram_address  out  ADDR_W  to RAM
ram_byteenable  out  DATA_W/8  to RAM
ram_chipselect  out  1  to RAM
ram_write  out  1  to RAM
ram_writedata  out  DATA_W  to RAM
ram_clken  out  1  RAM clock enable
ram_readdata  in  DATA_W  from RAM; valid the cycle after the address is clocked
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset_n low, asynchronous): last_grant=1, so m0 wins first; rd_vld=0; rd_owner=0; proto_err=0; lock_owner=none. All mX_readdatavalid=0. ram_chipselect=0 and ram_write=0 are combinational and fall to 0 with no request present.
- Request: reqX = mX_read | mX_write. The requester must hold all signals stable while mX_waitrequest=1.
- Grant is combinational from the registered last_grant pointer.
  - Only one request: that requester is granted.
  - Both request: the requester not equal to last_grant is granted.
  - last_grant updates to the winner on each granted cycle. It holds when nothing is granted.
- freeze=1: no grant is issued, and mX_waitrequest = reqX. ram_clken = ~freeze.
- mX_waitrequest = reqX & ~grantX. It is 0 when reqX=0.
- Granted cycle:
  - ram_chipselect=1.
  - ram_address, ram_byteenable and ram_writedata are muxed from the winner.
  - ram_write = winner's write.
  - Writes complete in the grant cycle.
- Read return:
  - A granted read sets rd_vld=1 and rd_owner=winner at the next edge.
  - mX_readdatavalid = rd_vld & (rd_owner==X). Latency is exactly 1 cycle after acceptance.
  - mX_readdata = ram_readdata for both ports; it is qualified only by readdatavalid.
  - Back-to-back reads from alternating requesters return in issue order, one per cycle.
  - A read accepted the cycle before freeze rises is still returned.
- Read and write asserted together by one requester: treated as a write, and proto_err is set. proto_err is cleared only by reset.
- Idle cycle: ram_chipselect=0, ram_write=0. Address and data outputs hold the m0 values (don't-care).
- Reset mid-read: a pending rd_vld is discarded and no readdatavalid is emitted.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined:
  - A granted transaction with mX_lock=1 sets lock_owner=X.
  - While locked, the other requester's waitrequest stays 1 regardless of round-robin.
  - A granted owner transaction with mX_lock=0 releases the lock after that transaction.
  - An idle counter counts owner cycles with reqX=0. On reaching LOCK_MAX it force-releases the lock and sets proto_err.
  - freeze pauses the idle counter.
- Not defined: the mX_lock ports exist but are ignored; there is no lock_owner or counter logic.

Test Plan:
1. m0 write addr 0x005 data 0xA5A5_1234 be 0xF, then m0 read 0x005 -> m0_waitrequest=0 on both, m0_readdatavalid exactly 1 cycle after read accept with 0xA5A5_1234, m1_readdatavalid stays 0.
2. m0 and m1 both reading continuously (addrs 0x010, 0x020) from reset -> grants m0,m1,m0,m1; each waits every other cycle; readdatavalid alternates with correct owner and data.
3. m1 write 0x7FF data 0xFFFF_FFFF, then m1 write 0x7FF data 0x0000_00AB be 0x1, read back -> 0xFFFF_FFAB (address wrap boundary 2047 reachable).
4. m0 read accepted, freeze high next cycle for 3 cycles with m1 requesting -> m0 data still returned; m1_waitrequest=1 and ram_clken=0 for all 3 cycles; m1 granted the first cycle after freeze falls.
5. m0 asserts read and write together at 0x001 -> write performed, no readdatavalid, proto_err=1 until reset_n pulse; reset_n low in the cycle after an accepted read -> no readdatavalid.
6. (ARB_LOCK_EN) m0 locked read then idles with lock held, m1 requesting -> m1 blocked for exactly LOCK_MAX=64 cycles, then granted, proto_err=1.

Source files
------------

// File: rtl/alarm_clk_ram_arbiter.sv
// alarm_clk_ram_arbiter
//   Shares one single-port RAM (1-cycle read latency, byte-enabled) between the Nios data master
//   (m0) and the alarm/time-keeping engine (m1). Each requester sees an Avalon-MM pipelined
//   slave. Round-robin grant, one transaction per clock, read data routed back to the issuer.
//
// Optional feature: define ARB_LOCK_EN to enable mX_lock (grant hold with idle timeout).
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   freeze                  debug stall; blocks all new grants and gates ram_clken
//   mX_address/byteenable/read/write/writedata/lock   requester X inputs (X = 0, 1)
//   mX_waitrequest/readdata/readdatavalid             requester X outputs
//   ram_address/byteenable/chipselect/write/writedata/clken   RAM controls
//   ram_readdata            RAM output, valid the cycle after the address is clocked
//   proto_err               sticky protocol-error flag, cleared only by reset
module alarm_clk_ram_arbiter #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,

  output logic                proto_err
);

  logic req0, req1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic granted;
  logic win;          // 0 = m0, 1 = m1; defaults to m0 when idle
  logic win_read, win_write;

  logic last_grant_q, last_grant_d;
  logic rd_vld_q, rd_vld_d;
  logic rd_owner_q, rd_owner_d;
  logic proto_err_q, proto_err_d;

  // Lock interface into the arbiter core
  logic lock_block0, lock_block1;
  logic lock_err;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic             lock_active_q, lock_active_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             owner_req;
  logic             win_lock;

  assign owner_req = lock_owner_q ? req1 : req0;
  assign win_lock  = win ? m1_lock : m0_lock;

  // The non-owner is held off regardless of round-robin state.
  assign lock_block0 = lock_active_q & lock_owner_q;
  assign lock_block1 = lock_active_q & ~lock_owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      idle_cnt_q    <= '0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  always_comb begin
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    idle_cnt_d    = idle_cnt_q;
    lock_err      = 1'b0;
    if (granted) begin
      idle_cnt_d = '0;
      if (win_lock) begin
        lock_active_d = 1'b1;
        lock_owner_d  = win;
      end else if (lock_active_q && (win == lock_owner_q)) begin
        lock_active_d = 1'b0;
      end
    end else if (lock_active_q && !freeze && !owner_req) begin
      // Owner sat idle too long: drop the lock and flag it.
      if (idle_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
        lock_active_d = 1'b0;
        idle_cnt_d    = '0;
        lock_err      = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign lock_block0 = 1'b0;
  assign lock_block1 = 1'b0;
  assign lock_err    = 1'b0;
`endif

  assign elig0 = req0 & ~lock_block0;
  assign elig1 = req1 & ~lock_block1;

  // Grant: combinational from last_grant_q; on contention the requester that did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!freeze) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign granted   = grant0 | grant1;
  assign win       = grant1;
  assign win_read  = win ? m1_read  : m0_read;
  assign win_write = win ? m1_write : m0_write;

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_vld_q     <= 1'b0;
      rd_owner_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_vld_q     <= rd_vld_d;
      rd_owner_q   <= rd_owner_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Next-state
  always_comb begin
    last_grant_d = granted ? win : last_grant_q;
    // Read+write together is executed as a write, so no read data comes back.
    rd_vld_d     = granted & win_read & ~win_write;
    rd_owner_d   = rd_vld_d ? win : rd_owner_q;
    proto_err_d  = proto_err_q | (m0_read & m0_write) | (m1_read & m1_write) | lock_err;
  end

  // Outputs
  always_comb begin
    m0_waitrequest   = req0 & ~grant0;
    m1_waitrequest   = req1 & ~grant1;
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    m0_readdatavalid = rd_vld_q & ~rd_owner_q;
    m1_readdatavalid = rd_vld_q & rd_owner_q;
    ram_chipselect   = granted;
    ram_write        = granted & win_write;
    ram_address      = win ? m1_address    : m0_address;
    ram_byteenable   = win ? m1_byteenable : m0_byteenable;
    ram_writedata    = win ? m1_writedata  : m0_writedata;
    ram_clken        = ~freeze;
    proto_err        = proto_err_q;
  end

endmodule

// File: tb/tb_alarm_clk_ram_arbiter.sv
// Directed self-checking bench for alarm_clk_ram_arbiter with a behavioural 2048x32 RAM model.
module tb_alarm_clk_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze;
  logic [10:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alarm_clk_ram_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .freeze           (freeze),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_lock          (m0_lock),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_lock          (m1_lock),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .proto_err        (proto_err)
  );

  // RAM model: byte-enabled write, registered read output, clock-enabled.
  logic [31:0] mem [2048];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    freeze = 0;
    m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0; m0_writedata = '0;
    m0_lock = 0;
    m1_address = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0; m1_writedata = '0;
    m1_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  // Stimulus-only helper: single uncontended m0 write.
  task automatic m0_wr(input logic [10:0] a, input logic [31:0] d);
    m0_address = a; m0_writedata = d; m0_byteenable = 4'hF; m0_write = 1;
    tick();
    m0_write = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m0_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL rst_m0_rdv got=%0b exp=0", m0_readdatavalid); end
    checks++; if (m1_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL rst_m1_rdv got=%0b exp=0", m1_readdatavalid); end
    checks++; if (proto_err !== 1'b0) begin failures++;
      $display("FAIL rst_proto_err got=%0b exp=0", proto_err); end
    checks++; if ({ram_chipselect, ram_write} !== 2'b00) begin failures++;
      $display("FAIL rst_ram_cs_wr got=%0b%0b exp=00", ram_chipselect, ram_write); end
    checks++; if ({m0_waitrequest, m1_waitrequest, ram_clken} !== 3'b001) begin failures++;
      $display("FAIL rst_wait_clken got=%b exp=001", {m0_waitrequest, m1_waitrequest, ram_clken});
    end
  endtask

  task automatic test_basic_rw();
    m0_address = 11'h005; m0_writedata = 32'hA5A5_1234; m0_byteenable = 4'hF; m0_write = 1;
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin failures++;
      $display("FAIL t1_wr_wait got=%0b exp=0", m0_waitrequest); end
    checks++; if ({ram_chipselect, ram_write, ram_address} !== {2'b11, 11'h005}) begin failures++;
      $display("FAIL t1_wr_ram got cs=%0b wr=%0b a=%h exp 1 1 005",
               ram_chipselect, ram_write, ram_address); end
    tick();
    m0_write = 0; m0_read = 1;
    #1;
    checks++; if ({m0_waitrequest, ram_write, ram_chipselect} !== 3'b001) begin failures++;
      $display("FAIL t1_rd_accept got=%b exp=001", {m0_waitrequest, ram_write, ram_chipselect});
    end
    tick();
    m0_read = 0;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA5A5_1234) begin failures++;
      $display("FAIL t1_rd_data got v=%0b d=%h exp v=1 d=a5a51234",
               m0_readdatavalid, m0_readdata); end
    checks++; if (m1_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL t1_m1_rdv got=%0b exp=0", m1_readdatavalid); end
    tick();
    checks++; if (m0_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL t1_rdv_once got=%0b exp=0", m0_readdatavalid); end
  endtask

  task automatic test_back_to_back();
    logic prev_m0;
    logic exp_m0;
    m0_wr(11'h010, 32'h1111_0010);
    m0_wr(11'h020, 32'h2222_0020);
    do_reset();
    m0_address = 11'h010; m0_read = 1;
    m1_address = 11'h020; m1_read = 1;
    prev_m0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_m0 = (k % 2 == 0);
      checks++; if (m0_waitrequest !== !exp_m0 || m1_waitrequest !== exp_m0) begin failures++;
        $display("FAIL t2_wait_k%0d got=%0b%0b exp=%0b%0b", k, m0_waitrequest, m1_waitrequest,
                 !exp_m0, exp_m0); end
      if (k > 0) begin
        checks++;
        if (m0_readdatavalid !== prev_m0 || m1_readdatavalid !== !prev_m0 ||
            m0_readdata !== (prev_m0 ? 32'h1111_0010 : 32'h2222_0020)) begin failures++;
          $display("FAIL t2_ret_k%0d got v0=%0b v1=%0b d=%h exp v0=%0b", k, m0_readdatavalid,
                   m1_readdatavalid, m0_readdata, prev_m0); end
      end
      prev_m0 = exp_m0;
      tick();
    end
    m0_read = 0; m1_read = 0;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1111_0010) begin failures++;
      $display("FAIL t2_last got v=%0b d=%h exp v=1 d=11110010", m0_readdatavalid, m0_readdata);
    end
    tick();
  endtask

  task automatic test_byte_enable_wrap();
    m1_address = 11'h7FF; m1_writedata = 32'hFFFF_FFFF; m1_byteenable = 4'hF; m1_write = 1;
    tick();
    m1_writedata = 32'h0000_00AB; m1_byteenable = 4'h1;
    #1;
    checks++; if (ram_byteenable !== 4'h1 || ram_address !== 11'h7FF) begin failures++;
      $display("FAIL t3_be got be=%h a=%h exp be=1 a=7ff", ram_byteenable, ram_address); end
    tick();
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    tick();
    m1_read = 0;
    checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hFFFF_FFAB) begin failures++;
      $display("FAIL t3_rd got v=%0b d=%h exp v=1 d=ffffffab", m1_readdatavalid, m1_readdata);
    end
    checks++; if (m0_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL t3_m0_rdv got=%0b exp=0", m0_readdatavalid); end
    tick();
  endtask

  task automatic test_freeze();
    m0_address = 11'h010; m0_read = 1;
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin failures++;
      $display("FAIL t4_accept got=%0b exp=0", m0_waitrequest); end
    tick();
    m0_read = 0; freeze = 1; m1_address = 11'h020; m1_read = 1;
    #1;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1111_0010) begin failures++;
      $display("FAIL t4_ret got v=%0b d=%h exp v=1 d=11110010", m0_readdatavalid, m0_readdata);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (m1_waitrequest !== 1'b1 || ram_clken !== 1'b0 || ram_chipselect !== 1'b0) begin
        failures++;
        $display("FAIL t4_frz_c%0d got wait=%0b clken=%0b cs=%0b exp 1 0 0", c, m1_waitrequest,
                 ram_clken, ram_chipselect); end
      tick();
      if (c == 2) freeze = 0;
      #1;
    end
    checks++; if (m1_waitrequest !== 1'b0 || ram_address !== 11'h020 || ram_clken !== 1'b1) begin
      failures++;
      $display("FAIL t4_unfrz got wait=%0b a=%h clken=%0b exp 0 020 1", m1_waitrequest,
               ram_address, ram_clken); end
    tick();
    m1_read = 0;
    checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h2222_0020) begin failures++;
      $display("FAIL t4_m1_ret got v=%0b d=%h exp v=1 d=22220020", m1_readdatavalid, m1_readdata);
    end
    tick();
  endtask

  task automatic test_proto_err_and_reset();
    m0_address = 11'h001; m0_writedata = 32'h0BAD_F00D; m0_read = 1; m0_write = 1;
    #1;
    checks++; if (m0_waitrequest !== 1'b0 || ram_write !== 1'b1) begin failures++;
      $display("FAIL t5_rw_wr got wait=%0b wr=%0b exp 0 1", m0_waitrequest, ram_write); end
    tick();
    m0_read = 0; m0_write = 0;
    checks++; if (proto_err !== 1'b1 || m0_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL t5_err got err=%0b rdv=%0b exp 1 0", proto_err, m0_readdatavalid); end
    checks++; if (mem[1] !== 32'h0BAD_F00D) begin failures++;
      $display("FAIL t5_mem got=%h exp=0badf00d", mem[1]); end
    tick();
    tick();
    m0_read = 1;
    tick();
    m0_read = 0;
    checks++; if (proto_err !== 1'b1) begin failures++;
      $display("FAIL t5_sticky got=%0b exp=1", proto_err); end
    reset_n = 0;
    #1;
    checks++; if (m0_readdatavalid !== 1'b0 || proto_err !== 1'b0) begin failures++;
      $display("FAIL t5_rst_mid got rdv=%0b err=%0b exp 0 0", m0_readdatavalid, proto_err); end
    tick();
    reset_n = 1;
    tick();
    checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin failures++;
      $display("FAIL t5_after_rst got %0b%0b exp 00", m0_readdatavalid, m1_readdatavalid); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock_timeout();
    int blocked;
    do_reset();
    m0_address = 11'h010; m0_read = 1; m0_lock = 1;
    m1_address = 11'h020; m1_read = 1;
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin failures++;
      $display("FAIL t6_lock_grant got=%0b exp=0", m0_waitrequest); end
    tick();
    m0_read = 0;
    blocked = 0;
    while (m1_waitrequest === 1'b1 && blocked < 200) begin
      blocked++;
      tick();
    end
    checks++; if (blocked != 64) begin failures++;
      $display("FAIL t6_blocked got=%0d exp=64", blocked); end
    checks++; if (proto_err !== 1'b1) begin failures++;
      $display("FAIL t6_err got=%0b exp=1", proto_err); end
    m0_lock = 0; m1_read = 0;
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_basic_rw();
    test_back_to_back();
    test_byte_enable_wrap();
    test_freeze();
    test_proto_err_and_reset();
`ifdef ARB_LOCK_EN
    test_lock_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
